ps2_rx: RTL
===========

// Module: ps2_rx
// PURPOSE
//  PS/2 device-to-host frame receiver; upstream of the keyboard event decoder/FIFO stage.
//  Syncs and deglitches raw PS/2 clock/data pins, then deserialises 11-bit frames (start, 8 data LSB-first, odd parity, stop).
//  Emits each good byte as ps2_key_data_o with a 1-cycle ps2_key_data_en_o strobe in the ps2_clk_i domain.
// PARAMETERS
//  FILTER_LEN      8      cycles a pin must hold a new level before the filtered copy follows (>=2)
//  TIMEOUT_CYCLES  50000  idle cycles mid-frame before abort (1 ms @ 50 MHz); counter width $clog2(TIMEOUT_CYCLES+1)
// PORTS
//  ps2_clk_i          in   1  PS/2 domain system clock; all logic on posedge
//  rst_i              in   1  asynchronous reset, active-high
//  ps2_line_clk_i     in   1  raw PS/2 CLK pin (async, open-drain, idle 1)
//  ps2_line_dat_i     in   1  raw PS/2 DATA pin (async, idle 1)
//  ps2_key_data_o     out  8  last received scan-code byte
//  ps2_key_data_en_o  out  1  1-cycle strobe: ps2_key_data_o valid and new
//  frame_err_o        out  1  1-cycle strobe: frame dropped (bad start/stop/parity or timeout)
// BEHAVIOUR
//  Reset: ps2_key_data_o=8'h00, ps2_key_data_en_o=0, frame_err_o=0, FSM=IDLE, filtered lines=1, bit/timeout counters=0.
//  Input path per pin: 2-flop sync -> filter; filtered level changes after FILTER_LEN consecutive equal samples.
//  Sampling event = filtered clock 1->0 (registered edge detect); data sampled from filtered data at that cycle.
//  FSM (ps2_rx_state_t): IDLE -> DATA -> PARITY -> STOP -> IDLE.
//   IDLE: on event, dat=0 -> DATA, bit_cnt=0; dat=1 -> stay IDLE, frame_err_o pulse.
//   DATA: on event shift dat into shreg[bit_cnt] (LSB first); after 8th bit -> PARITY.
//   PARITY: on event latch parity bit -> STOP.
//   STOP: on event -> IDLE; if dat=1 (and parity ok, see CONFIGURATION) then next cycle
//         ps2_key_data_o<=shreg, ps2_key_data_en_o=1; else frame_err_o=1, ps2_key_data_o unchanged.
//  Latency: strobe asserts exactly 1 cycle after the stop-bit sampling event.
//  Timeout: counter clears on every event and while in IDLE; in any non-IDLE state reaching
//   TIMEOUT_CYCLES -> IDLE, frame_err_o pulse, partial byte discarded, no data strobe.
//  en_o and err_o never both 1 in one cycle; back-to-back frames need no gap beyond PS/2 timing.
//  Reset mid-frame: abort immediately, no strobe; next full frame received normally.
//  No backpressure: downstream samples on strobe; byte stays stable until next good frame.
// CONFIGURATION
//  PS2_RX_PARITY_CHECK_EN defined: byte accepted only if ^{shreg,parity}==1 (odd); else frame_err_o, no strobe.
//  Not defined: parity bit sampled and ignored; only start/stop/timeout cause frame_err_o.
// STRUCTURE
//  Shared package (defs.vh): ps2_rx_state_t enum {IDLE,DATA,PARITY,STOP}, PS2_DATA_BITS=8, PS2_FRAME_BITS=11.
//  Sub-module ps2_line_filter (#FILTER_LEN): sync + deglitch for one pin, reset value 1; instantiated for clk and dat.
//  Top: edge detect, FSM, shift register, bit counter, timeout counter, output regs.
// TESTING (bench drives pins at 12.5 kHz PS/2 rate, FILTER_LEN=8, TIMEOUT_CYCLES=50000)
//  Frame 0x75 parity=0 stop=1 -> one en pulse, data_o=8'h75, err_o=0 throughout.
//  Frames E0,F0,75 back-to-back -> three en pulses, data 8'hE0,8'hF0,8'h75 in order.
//  Frame 0x75 parity=1 -> with PS2_RX_PARITY_CHECK_EN: err_o pulse, no en, data_o holds previous; without: en pulse, data_o=8'h75.
//  Frame 0x1C with stop=0 -> err_o pulse, no en; following good 0x1C -> en, data_o=8'h1C.
//  Pins held after 5 bits for 50001 cycles -> err_o pulse, FSM IDLE; next frame 0x6B -> en, data_o=8'h6B.
//  3-cycle low glitch on line clk while IDLE -> no event, no err_o; rst_i mid-frame -> outputs 0, next frame 0x74 received.

Source files
------------

// File: rtl/ps2_rx_pkg.sv
// Shared definitions for the PS/2 receive path: frame geometry, FSM state
// type and the odd-parity rule used when PS2_RX_PARITY_CHECK_EN is defined.
package ps2_rx_pkg;

  localparam int PS2_DATA_BITS  = 8;
  localparam int PS2_FRAME_BITS = 11;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DATA   = 2'd1,
    PARITY = 2'd2,
    STOP   = 2'd3
  } ps2_rx_state_t;

  // PS/2 uses odd parity: data bits plus parity bit must contain an odd
  // number of ones.
  function automatic logic odd_parity_ok(input logic [PS2_DATA_BITS-1:0] data,
                                         input logic parity);
    return ^{data, parity};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser plus deglitch filter for one raw PS/2 pin. The filtered
// output only follows the synchronised pin once it has shown the new level
// for FILTER_LEN consecutive cycles. Idles (and resets) high like the bus.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic line_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          filt_q;

  // Two-flop synchroniser for the asynchronous pin.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], line_i};
    end
  end

  // Count consecutive samples that disagree with the filtered level; any
  // agreeing sample restarts the count, so short glitches never get through.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q  <= '0;
      filt_q <= 1'b1;
    end else if (sync_q[1] == filt_q) begin
      cnt_q <= '0;
    end else if (cnt_q == CW'(FILTER_LEN - 1)) begin
      filt_q <= sync_q[1];
      cnt_q  <= '0;
    end else begin
      cnt_q <= cnt_q + CW'(1);
    end
  end

  assign line_o = filt_q;

endmodule

// File: rtl/ps2_rx.sv
// PS/2 device-to-host frame receiver. Filters both pins, detects falling
// edges of the filtered clock and deserialises start/8 data/parity/stop
// frames. Good bytes are presented with a one-cycle strobe; dropped frames
// (bad start, bad stop, timeout, and bad parity when checked) give a
// one-cycle error strobe instead.
// Optional feature: define PS2_RX_PARITY_CHECK_EN to reject frames whose
// parity is not odd; otherwise the parity bit is consumed and ignored.
module ps2_rx
  import ps2_rx_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic       ps2_clk_i,
  input  logic       rst_i,
  input  logic       ps2_line_clk_i,
  input  logic       ps2_line_dat_i,
  output logic [7:0] ps2_key_data_o,
  output logic       ps2_key_data_en_o,
  output logic       frame_err_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int BW = $clog2(PS2_DATA_BITS);

  logic clk_f;
  logic dat_f;
  logic clk_f_q;
  logic sample_ev;
  logic timeout_hit;
  logic parity_ok;

  ps2_rx_state_t            state_q,   state_d;
  logic [BW-1:0]            bit_cnt_q, bit_cnt_d;
  logic [PS2_DATA_BITS-1:0] shreg_q,   shreg_d;
  logic [TW-1:0]            tmo_q,     tmo_d;
  logic [7:0]               data_q,    data_d;
  logic                     en_q,      en_d;
  logic                     err_q,     err_d;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .clk_i  (ps2_clk_i),
    .rst_i  (rst_i),
    .line_i (ps2_line_clk_i),
    .line_o (clk_f)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
    .clk_i  (ps2_clk_i),
    .rst_i  (rst_i),
    .line_i (ps2_line_dat_i),
    .line_o (dat_f)
  );

  // Previous filtered clock level, for falling-edge detection.
  always_ff @(posedge ps2_clk_i or posedge rst_i) begin
    if (rst_i) begin
      clk_f_q <= 1'b1;
    end else begin
      clk_f_q <= clk_f;
    end
  end

  assign sample_ev   = clk_f_q & ~clk_f;
  assign timeout_hit = (tmo_q == TW'(TIMEOUT_CYCLES));

`ifdef PS2_RX_PARITY_CHECK_EN
  logic parity_q, parity_d;

  // Parity bit as sampled in the PARITY state.
  always_ff @(posedge ps2_clk_i or posedge rst_i) begin
    if (rst_i) begin
      parity_q <= 1'b0;
    end else begin
      parity_q <= parity_d;
    end
  end

  // Latch the parity bit on the sampling event of the PARITY state.
  always_comb begin
    parity_d = parity_q;
    if (sample_ev && state_q == PARITY) begin
      parity_d = dat_f;
    end
  end

  assign parity_ok = odd_parity_ok(shreg_q, parity_q);
`else
  assign parity_ok = 1'b1;
`endif

  // Frame FSM, shift register, bit counter, inactivity timeout and the
  // next values of the output registers.
  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tmo_d     = tmo_q;
    data_d    = data_q;
    en_d      = 1'b0;
    err_d     = 1'b0;

    // The timeout only runs mid-frame and restarts on every clock edge.
    if (state_q == IDLE || sample_ev) begin
      tmo_d = '0;
    end else if (!timeout_hit) begin
      tmo_d = tmo_q + TW'(1);
    end

    case (state_q)
      IDLE: begin
        if (sample_ev) begin
          if (!dat_f) begin
            state_d   = DATA;
            bit_cnt_d = '0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      DATA: begin
        if (sample_ev) begin
          shreg_d[bit_cnt_q] = dat_f;
          if (bit_cnt_q == BW'(PS2_DATA_BITS - 1)) begin
            state_d = PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end
      PARITY: begin
        if (sample_ev) begin
          state_d = STOP;
        end
      end
      STOP: begin
        if (sample_ev) begin
          state_d = IDLE;
          if (dat_f && parity_ok) begin
            data_d = shreg_q;
            en_d   = 1'b1;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // A stalled frame is abandoned; the partial byte is simply left behind.
    if (state_q != IDLE && !sample_ev && timeout_hit) begin
      state_d   = IDLE;
      bit_cnt_d = '0;
      err_d     = 1'b1;
    end
  end

  // State and output registers.
  always_ff @(posedge ps2_clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tmo_q     <= '0;
      data_q    <= 8'h00;
      en_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tmo_q     <= tmo_d;
      data_q    <= data_d;
      en_q      <= en_d;
      err_q     <= err_d;
    end
  end

  assign ps2_key_data_o    = data_q;
  assign ps2_key_data_en_o = en_q;
  assign frame_err_o       = err_q;

endmodule
